// File: rtl/ff_ce_gen.sv
// Programmable clock-enable strobe generator for ff_dffre register banks.
// Emits 1-cycle CE strobes every DIV+1 clocks (free-run or NPULSE-limited), with a CLR on every start.
module ff_ce_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             STOP,
  input  logic [DIV_W-1:0] DIV,
  input  logic             ONESHOT,
  input  logic [CNT_W-1:0] NPULSE,
  output logic             CE,
  output logic             CLR,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;
  logic             oneshot_q, oneshot_nxt;
  logic [CNT_W-1:0] left, left_nxt;
  logic             ce_nxt, clr_nxt, done_nxt;
  logic             start_run, start_empty;
  logic [DIV_W-1:0] first_cnt;

  assign start_run   = START && !STOP && (!ONESHOT || (NPULSE != '0));
  assign start_empty = START && !STOP && ONESHOT && (NPULSE == '0);
  // The START edge itself counts as the first edge of the first period.
  assign first_cnt   = (DIV == '0) ? '0 : (DIV - DIV_ONE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    div_nxt     = div_q;
    oneshot_nxt = oneshot_q;
    left_nxt    = left;
    ce_nxt      = 1'b0;
    clr_nxt     = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start_run) begin
          div_nxt     = DIV;
          oneshot_nxt = ONESHOT;
          left_nxt    = NPULSE;
          cnt_nxt     = first_cnt;
          clr_nxt     = 1'b1;
          state_nxt   = RUN;
        end else if (start_empty) begin
          done_nxt = 1'b1;
        end
      end
      RUN: begin
        if (STOP) begin
          state_nxt = IDLE;
        end else if (start_run) begin
          div_nxt     = DIV;
          oneshot_nxt = ONESHOT;
          left_nxt    = NPULSE;
          cnt_nxt     = first_cnt;
          clr_nxt     = 1'b1;
        end else if (start_empty) begin
          div_nxt     = DIV;
          oneshot_nxt = ONESHOT;
          left_nxt    = NPULSE;
          done_nxt    = 1'b1;
          state_nxt   = IDLE;
        end else if (oneshot_q && (left == '0)) begin
          // Last strobe went out on the previous edge; close the run now.
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          ce_nxt  = 1'b1;
          cnt_nxt = div_q;
          if (oneshot_q) left_nxt = left - CNT_ONE;
        end else begin
          cnt_nxt = cnt - DIV_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      cnt       <= '0;
      div_q     <= '0;
      oneshot_q <= 1'b0;
      left      <= '0;
      CE        <= 1'b0;
      CLR       <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      div_q     <= div_nxt;
      oneshot_q <= oneshot_nxt;
      left      <= left_nxt;
      CE        <= ce_nxt;
      CLR       <= clr_nxt;
      BUSY      <= (state_nxt == RUN);
      DONE      <= done_nxt;
    end
  end

endmodule
